// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// mips_defs -- constants and types shared by the fetch stage.
//   PC_RESET  : fetch address after reset
//   IM_BASE   : first word of instruction memory
//   IM_LAST   : last word of instruction memory
//   EXC_ADEL  : exception code for an instruction-fetch address error
//   NOP_INSTR : encoding placed in an annulled or faulting D slot
//   if_id_t   : contents of the IF/ID pipeline register
// -----------------------------------------------------------------------------
package mips_defs;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] IM_BASE   = 32'h0000_3000;
  localparam logic [31:0] IM_LAST   = 32'h0000_6FFC;
  localparam logic [4:0]  EXC_ADEL  = 5'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        exc;
    logic [4:0]  exccode;
  } if_id_t;

  // A fetch faults when it is misaligned or lies outside instruction memory.
  function automatic logic fetch_addr_bad(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_if -- link between the fetch stage and its PC register.
//   en  : load npc on the next rising edge (low while the pipeline is stalled)
//   npc : next fetch address
//   pc  : current fetch address held by the register
// master = fetch_stage (drives en/npc), slave = if_pc_reg (drives pc).
// -----------------------------------------------------------------------------
interface fetch_pc_if;

  logic        en;
  logic [31:0] npc;
  logic [31:0] pc;

  modport master (output en, output npc, input pc);
  modport slave  (input en, input npc, output pc);

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// -----------------------------------------------------------------------------
// if_pc_reg -- program-counter register with load enable.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high; forces PC_RESET
//   pc_bus : fetch_pc_if slave (en, npc in; pc out)
// -----------------------------------------------------------------------------
module if_pc_reg
  import mips_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  fetch_pc_if.slave  pc_bus
);

  logic [31:0] pc_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= PC_RESET;
    end else if (pc_bus.en) begin
      pc_q <= pc_bus.npc;
    end
  end

  assign pc_bus.pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage -- instruction fetch (IF) stage and IF/ID pipeline register.
//   clk       : rising-edge clock
//   reset     : asynchronous, active-high
//   stall     : freezes PC, IF/ID register and fetch counter (beats add_nop)
//   npc       : next PC from the next-PC unit
//   add_nop   : annul the instruction fetched this cycle
//   instr_in  : instruction-memory data for pc_f
//   pc_f      : current fetch PC (instruction-memory address)
//   ir_d      : D-stage instruction
//   pc_d      : D-stage instruction address
//   pc4_d     : pc_d + 4
//   valid_d   : D slot holds a real instruction
//   exc_d     : D-stage instruction carries a fetch exception
//   exccode_d : exception code for exc_d
//   fetch_cnt : number of valid instructions latched into D (wraps silently)
// Build option: define FETCH_ADEL_EN to raise AdEL on misaligned or
// out-of-range fetches; otherwise exc_d/exccode_d are tied to zero.
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module fetch_stage
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] npc,
  input  logic        add_nop,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_f,
  output logic [31:0] ir_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc4_d,
  output logic        valid_d,
  output logic        exc_d,
  output logic [4:0]  exccode_d,
  output logic [31:0] fetch_cnt
);

  fetch_pc_if pc_bus ();

  assign pc_bus.en  = ~stall;
  assign pc_bus.npc = npc;

  if_pc_reg u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .pc_bus (pc_bus)
  );

  assign pc_f = pc_bus.pc;

  if_id_t      if_id_q, if_id_d;
  logic [31:0] cnt_q, cnt_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    if_id_d = if_id_q;
    cnt_d   = cnt_q;
    if (!stall) begin
      if_id_d.pc  = pc_f;
      if_id_d.pc4 = pc_f + 32'd4;
      if (add_nop) begin
        if_id_d.ir      = NOP_INSTR;
        if_id_d.valid   = 1'b0;
        if_id_d.exc     = 1'b0;
        if_id_d.exccode = 5'd0;
      end else begin
        // A faulting fetch still occupies a valid slot so the exception
        // travels down the pipe; it therefore counts as a fetch.
        if_id_d.valid = 1'b1;
        cnt_d         = cnt_q + 32'd1;
`ifdef FETCH_ADEL_EN
        if (fetch_addr_bad(pc_f)) begin
          if_id_d.ir      = NOP_INSTR;
          if_id_d.exc     = 1'b1;
          if_id_d.exccode = EXC_ADEL;
        end else begin
          if_id_d.ir      = instr_in;
          if_id_d.exc     = 1'b0;
          if_id_d.exccode = 5'd0;
        end
`else
        if_id_d.ir      = instr_in;
        if_id_d.exc     = 1'b0;
        if_id_d.exccode = 5'd0;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_q <= '0;
      cnt_q   <= '0;
    end else begin
      if_id_q <= if_id_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ir_d      = if_id_q.ir;
  assign pc_d      = if_id_q.pc;
  assign pc4_d     = if_id_q.pc4;
  assign valid_d   = if_id_q.valid;
  assign exc_d     = if_id_q.exc;
  assign exccode_d = if_id_q.exccode;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage -- self-checking bench for fetch_stage.
// Directed scenarios followed by random traffic, all compared against a
// cycle-level reference model of the fetch/IF-ID behaviour.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] npc;
  logic        add_nop;
  logic [31:0] instr_in;
  logic [31:0] pc_f;
  logic [31:0] ir_d;
  logic [31:0] pc_d;
  logic [31:0] pc4_d;
  logic        valid_d;
  logic        exc_d;
  logic [4:0]  exccode_d;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc_f, m_ir, m_pc_d, m_pc4, m_cnt;
  logic        m_valid, m_exc;
  logic [4:0]  m_code;

  fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .npc       (npc),
    .add_nop   (add_nop),
    .instr_in  (instr_in),
    .pc_f      (pc_f),
    .ir_d      (ir_d),
    .pc_d      (pc_d),
    .pc4_d     (pc4_d),
    .valid_d   (valid_d),
    .exc_d     (exc_d),
    .exccode_d (exccode_d),
    .fetch_cnt (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc_f  = 32'h0000_3000;
    m_ir    = 32'h0;
    m_pc_d  = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
    m_exc   = 1'b0;
    m_code  = 5'd0;
    m_cnt   = 32'h0;
  endtask

  function automatic logic addr_error(input logic [31:0] a);
`ifdef FETCH_ADEL_EN
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
`else
    return 1'b0;
`endif
  endfunction

  // Apply one rising edge to the model using the inputs currently presented.
  task automatic model_edge();
    if (!stall) begin
      m_pc_d = m_pc_f;
      m_pc4  = m_pc_f + 32'd4;
      if (add_nop) begin
        m_ir = 32'h0; m_valid = 1'b0; m_exc = 1'b0; m_code = 5'd0;
      end else begin
        m_valid = 1'b1;
        m_cnt   = m_cnt + 32'd1;
        if (addr_error(m_pc_f)) begin
          m_ir = 32'h0; m_exc = 1'b1; m_code = 5'd4;
        end else begin
          m_ir = instr_in; m_exc = 1'b0; m_code = 5'd0;
        end
      end
      m_pc_f = npc;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc_f"},      pc_f,              m_pc_f);
    check({tag, ".ir_d"},      ir_d,              m_ir);
    check({tag, ".pc_d"},      pc_d,              m_pc_d);
    check({tag, ".pc4_d"},     pc4_d,             m_pc4);
    check({tag, ".valid_d"},   {31'd0, valid_d},  {31'd0, m_valid});
    check({tag, ".exc_d"},     {31'd0, exc_d},    {31'd0, m_exc});
    check({tag, ".exccode_d"}, {27'd0, exccode_d}, {27'd0, m_code});
    check({tag, ".fetch_cnt"}, fetch_cnt,         m_cnt);
  endtask

  // One clock edge: model follows the same inputs, outputs sampled 1 ns later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] hold_ir, hold_pc_f, hold_pc_d, hold_cnt;

    reset = 1'b1; stall = 1'b0; add_nop = 1'b0; npc = 32'h0; instr_in = 32'h0;
    model_reset();
    #2;
    check_all("reset");

    // Basic fetch after reset release
    @(posedge clk); #1;
    reset = 1'b0;
    npc = 32'h3004; instr_in = 32'h2408_0001;
    step("first");
    check("first.ir_const",  ir_d,      32'h2408_0001);
    check("first.pc_d",      pc_d,      32'h3000);
    check("first.pc4_d",     pc4_d,     32'h3004);
    check("first.pc_f",      pc_f,      32'h3004);
    check("first.cnt",       fetch_cnt, 32'd1);

    // Three stalled edges with npc moving
    hold_ir = ir_d; hold_pc_f = pc_f; hold_pc_d = pc_d; hold_cnt = fetch_cnt;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      npc = 32'h3100 + 32'(i) * 4; instr_in = $urandom;
      step("stall");
    end
    check("stall.pc_f_hold", pc_f,      hold_pc_f);
    check("stall.ir_hold",   ir_d,      hold_ir);
    check("stall.pc_d_hold", pc_d,      hold_pc_d);
    check("stall.cnt_hold",  fetch_cnt, hold_cnt);
    stall = 1'b0; npc = 32'h300C; instr_in = $urandom;
    step("resume");
    check("resume.pc_f", pc_f, 32'h300C);

    // Walk pc_f to 0x3010, then annul with npc = 0x3040
    npc = 32'h3010; instr_in = $urandom;
    step("walk");
    hold_cnt = fetch_cnt;
    add_nop = 1'b1; npc = 32'h3040; instr_in = $urandom;
    step("annul");
    check("annul.ir",    ir_d,             32'h0);
    check("annul.valid", {31'd0, valid_d}, 32'd0);
    check("annul.pc_d",  pc_d,             32'h3010);
    check("annul.pc_f",  pc_f,             32'h3040);
    check("annul.cnt",   fetch_cnt,        hold_cnt);

    // Normal fetch, then stall and add_nop on the same edge
    add_nop = 1'b0; npc = 32'h3044; instr_in = 32'hDEAD_BEEF;
    step("pre_both");
    hold_ir = ir_d;
    stall = 1'b1; add_nop = 1'b1; npc = 32'h3080; instr_in = $urandom;
    step("both");
    check("both.ir_keep", ir_d, hold_ir);
    stall = 1'b0; add_nop = 1'b0;

    // Misaligned fetch address
    npc = 32'h3002; instr_in = $urandom;
    step("mis_load");
    npc = 32'h3048; instr_in = 32'h1234_5678;
    step("mis_fetch");
    check("mis.pc_d", pc_d, 32'h3002);
`ifdef FETCH_ADEL_EN
    check("mis.exc",  {31'd0, exc_d},     32'd1);
    check("mis.code", {27'd0, exccode_d}, 32'd4);
    check("mis.ir",   ir_d,               32'h0);
`else
    check("mis.exc",  {31'd0, exc_d},     32'd0);
    check("mis.ir",   ir_d,               32'h1234_5678);
`endif

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      stall   = ($urandom_range(0, 3) == 0);
      add_nop = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) < 8) npc = 32'h3000 + 32'($urandom_range(0, 12'hFFF)) * 4;
      else                          npc = $urandom;
      instr_in = $urandom;
      step("rand");
    end

    // Asynchronous reset between edges while stalling/annulling
    stall = 1'b1; add_nop = 1'b1; npc = 32'h3ABC; instr_in = $urandom;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    #2;
    reset = 1'b0; stall = 1'b0; add_nop = 1'b0;
    npc = 32'h3004; instr_in = 32'hCAFE_0001;
    step("post_reset");
    check("post_reset.ir",   ir_d, 32'hCAFE_0001);
    check("post_reset.pc_d", pc_d, 32'h3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port stall  input  1  hazard-unit freeze of PC and IF/ID register.
REQ-004 SHALL have port npc  input  32  next PC from the next-PC unit.
REQ-005 SHALL have port add_nop  input  1  annul the instruction being fetched this cycle (likely-branch delay slot).
REQ-006 SHALL have port instr_in  input  32  instruction-memory read data for pc_f.
REQ-007 SHALL have port pc_f  output  32  current fetch PC, drives instruction-memory address.
REQ-008 SHALL have port ir_d  output  32  D-stage instruction.
REQ-009 SHALL have port pc_d  output  32  D-stage instruction address.
REQ-010 SHALL have port pc4_d  output  32  pc_d + 4, fed back to the next-PC unit.
REQ-011 SHALL have port valid_d  output  1  D-stage slot holds a real (non-annulled) instruction.
REQ-012 SHALL have port exc_d  output  1  D-stage instruction carries a fetch exception.
REQ-013 SHALL have port exccode_d  output  5  exception code for exc_d.
REQ-014 SHALL have port fetch_cnt  output  32  count of valid instructions latched into D.

Function
REQ-015 Edge with stall=0: pc_f<=npc; pc_d<=pc_f; pc4_d<=pc_f+4; ir_d<=instr_in; valid_d<=1; fetch_cnt increments by 1.
REQ-016 Edge with stall=0 and add_nop=1: pc_f<=npc; pc_d<=pc_f; pc4_d<=pc_f+4; ir_d<=0; valid_d<=0; exc_d<=0; fetch_cnt unchanged.
REQ-017 Edge with stall=1: pc_f, ir_d, pc_d, pc4_d, valid_d, exc_d, exccode_d, fetch_cnt all hold; stall overrides add_nop.
REQ-018 Latency: instr_in sampled at pc_f appears on ir_d exactly one cycle later; npc becomes pc_f one cycle after presentation.
REQ-019 pc4_d addition modulo 2^32; fetch_cnt wraps 0xFFFFFFFF->0 with no flag.
REQ-020 Outputs purely registered; no combinational path from any input to any output.

Reset
REQ-021 reset asserted: pc_f=0x00003000, ir_d=0, pc_d=0, pc4_d=0, valid_d=0, exc_d=0, exccode_d=0, fetch_cnt=0, immediately and independent of clk.
REQ-022 Reset mid-stall or mid-annul: reset wins; first edge after deassertion latches instr_in for 0x3000 into D.

Configuration
REQ-023 Macro FETCH_ADEL_EN defined: on an unstalled, non-annulled edge, if pc_f[1:0]!=0 or pc_f outside 0x3000..0x6FFC, latch ir_d=0, valid_d=1, exc_d=1, exccode_d=4 (AdEL); fetch_cnt still increments.
REQ-024 Macro FETCH_ADEL_EN undefined: no range/alignment check; exc_d and exccode_d constant 0; ports still present.

Structure
REQ-025 Shared package mips_defs SHALL hold PC_RESET (0x3000), IM_BASE (0x3000), IM_LAST (0x6FFC), EXC_ADEL (5'd4), NOP_INSTR (0).
REQ-026 PC register with reset/enable SHALL be sub-module if_pc_reg; IF/ID register and counter SHALL live in fetch_stage.

Verification
REQ-027 Reset, release, npc=0x3004, instr_in=0x24080001 -> after 1 edge ir_d=0x24080001, pc_d=0x3000, pc4_d=0x3004, valid_d=1, pc_f=0x3004, fetch_cnt=1.
REQ-028 stall=1 for 3 edges with npc changing -> pc_f, ir_d, pc_d, fetch_cnt unchanged; release -> resumes with current npc.
REQ-029 add_nop=1, pc_f=0x3010, npc=0x3040 -> ir_d=0, valid_d=0, pc_d=0x3010, pc_f=0x3040, fetch_cnt unchanged.
REQ-030 stall=1 and add_nop=1 same edge -> full hold; ir_d keeps prior value.
REQ-031 FETCH_ADEL_EN defined, npc=0x3002 -> next edge exc_d=1, exccode_d=4, ir_d=0, pc_d=0x3002; undefined -> exc_d=0, ir_d=instr_in.
REQ-032 Assert reset asynchronously between edges mid-run -> all outputs at reset values before next clk edge.
